// File: rtl/squash_input_conditioner.sv
// squash_input_conditioner: synchronises and debounces the active-low push-button
// pads and gates every key output on the synchronised gpio_ready strobe.

// Per-key debounce: accepts a new level after STABLE_SAMPLES consecutive differing ticks.
module squash_key_debounce #(
  parameter int STABLE_SAMPLES = 8,
  parameter int CW             = 4
) (
  input  logic wb_clk_i,
  input  logic rst_n,
  input  logic en_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic key_o,
  output logic press_o
);
  logic          d_q, d_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next state: clear while not ready, otherwise count disagreeing ticks.
  always_comb begin
    d_d     = d_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (!en_i) begin
      d_d   = 1'b0;
      cnt_d = '0;
    end else if (tick_i) begin
      if (raw_i == d_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(STABLE_SAMPLES - 1)) begin
        d_d     = raw_i;
        cnt_d   = '0;
        press_d = raw_i;   // pulse only on an accepted press, never on release
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign key_o   = d_q;
  assign press_o = press_q;
endmodule

module squash_input_conditioner #(
  parameter int NUM_KEYS       = 4,
  parameter int SAMPLE_DIV     = 256,
  parameter int STABLE_SAMPLES = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                wb_clk_i,
  input  logic                rst_n,
  input  logic                gpio_ready,
  input  logic [NUM_KEYS-1:0] keys_n_i,
  output logic [NUM_KEYS-1:0] keys_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic                sample_tick_o,
  output logic                ready_o
);
  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES + 1) : 1;

  logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] key_sync_q, key_sync_d;
  logic [SYNC_STAGES-1:0]               rdy_sync_q, rdy_sync_d;
  logic [PW-1:0]                        presc_q, presc_d;
  logic [NUM_KEYS-1:0]                  raw;
  logic                                 tick;

  // Synchroniser shift: stage 0 takes the pad, each later stage the previous one.
  always_comb begin
    key_sync_d    = key_sync_q;
    rdy_sync_d    = rdy_sync_q;
    key_sync_d[0] = keys_n_i;
    rdy_sync_d[0] = gpio_ready;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      key_sync_d[i] = key_sync_q[i-1];
      rdy_sync_d[i] = rdy_sync_q[i-1];
    end
  end

  // Sync chains reset to "released" pads and "not ready".
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      key_sync_q <= '1;
      rdy_sync_q <= '0;
    end else begin
      key_sync_q <= key_sync_d;
      rdy_sync_q <= rdy_sync_d;
    end
  end

  assign ready_o = rdy_sync_q[SYNC_STAGES-1];
  assign raw     = ~key_sync_q[SYNC_STAGES-1];
  assign tick    = ready_o && (presc_q == PW'(SAMPLE_DIV - 1));

  // Prescaler next count: parked at zero until ready, then wraps every SAMPLE_DIV.
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (!ready_o || tick) presc_d = '0;
  end

  // Prescaler register.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  assign sample_tick_o = tick;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    squash_key_debounce #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .CW            (CW)
    ) u_db (
      .wb_clk_i(wb_clk_i),
      .rst_n   (rst_n),
      .en_i    (ready_o),
      .tick_i  (tick),
      .raw_i   (raw[k]),
      .key_o   (keys_o[k]),
      .press_o (press_o[k])
    );
  end
endmodule
